// File: rtl/xgmii_pkg.sv
// Shared XGMII constants, lane-state encoding and idle-word detection for the
// loopback switch.
package xgmii_pkg;

    localparam int XGMII_DW = 64;
    localparam int XGMII_CW = XGMII_DW / 8;

    localparam logic [7:0] XGMII_IDLE_BYTE = 8'h07;
    localparam logic [7:0] XGMII_ERR_BYTE  = 8'hFE;

    localparam logic [XGMII_DW-1:0] XGMII_IDLE_WORD = {XGMII_CW{XGMII_IDLE_BYTE}};

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_TO_LB    = 2'd1,
        ST_LOOPBACK = 2'd2,
        ST_TO_NORM  = 2'd3
    } lane_state_e;

    // An XGMII word is idle only when every lane byte is a control 0x07.
    function automatic logic is_idle(input logic [XGMII_DW-1:0] d,
                                     input logic [XGMII_CW-1:0] c);
        return (c == {XGMII_CW{1'b1}}) && (d == XGMII_IDLE_WORD);
    endfunction

endpackage

// File: rtl/xgmii_lb_lane.sv
// One XGMII lane of the loopback switch: mode FSM, switch-timeout counter,
// output muxes and the registered outputs.
module xgmii_lb_lane
    import xgmii_pkg::*;
#(
    parameter int DATA_W        = 64,
    parameter int CTRL_W        = DATA_W / 8,
    parameter int TMO_W         = 12,
    parameter int TMO_CYC       = 2048,
    parameter int TX_IDLE_IN_LB = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] mac_txd,
    input  logic [CTRL_W-1:0] mac_txc,
    input  logic [DATA_W-1:0] pcs_rxd,
    input  logic [CTRL_W-1:0] pcs_rxc,
    input  logic              lb_req,
    input  logic              clr_forced,
    output logic [DATA_W-1:0] pcs_txd,
    output logic [CTRL_W-1:0] pcs_txc,
    output logic [DATA_W-1:0] mac_rxd,
    output logic [CTRL_W-1:0] mac_rxc,
    output logic              lb_active,
    output logic              forced_sw
);

    localparam logic [DATA_W-1:0] IDLE_W   = {CTRL_W{XGMII_IDLE_BYTE}};
    localparam logic [DATA_W-1:0] ERR_W    = {CTRL_W{XGMII_ERR_BYTE}};
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TMO_CYC - 1);

    lane_state_e       state_q, state_d;
    logic [TMO_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              forced_q, forced_d;
    logic              lb_active_q, lb_active_d;
    logic [DATA_W-1:0] mac_rxd_q, mac_rxd_d, pcs_txd_q, pcs_txd_d;
    logic [CTRL_W-1:0] mac_rxc_q, mac_rxc_d, pcs_txc_q, pcs_txc_d;
    logic              both_idle, timeout;

    always_comb begin
        both_idle = is_idle(mac_txd, mac_txc) && is_idle(pcs_rxd, pcs_rxc);
        timeout   = (cnt_q >= TMO_LAST);
        cnt_inc   = (cnt_q == {TMO_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

        state_d   = state_q;
        cnt_d     = cnt_q;
        forced_d  = clr_forced ? 1'b0 : forced_q;
        mac_rxd_d = pcs_rxd;
        mac_rxc_d = pcs_rxc;

        // Withdrawal beats the boundary, the boundary beats the timeout.
        case (state_q)
            ST_NORMAL: begin
                if (lb_req) begin
                    state_d = ST_TO_LB;
                    cnt_d   = '0;
                end
            end
            ST_TO_LB: begin
                if (!lb_req) begin
                    state_d = ST_NORMAL;
                end else if (both_idle) begin
                    mac_rxd_d = IDLE_W;
                    mac_rxc_d = '1;
                    state_d   = ST_LOOPBACK;
                end else if (timeout) begin
                    mac_rxd_d = ERR_W;
                    mac_rxc_d = '1;
                    forced_d  = 1'b1;
                    state_d   = ST_LOOPBACK;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_LOOPBACK: begin
                mac_rxd_d = mac_txd;
                mac_rxc_d = mac_txc;
                if (!lb_req) begin
                    state_d = ST_TO_NORM;
                    cnt_d   = '0;
                end
            end
            ST_TO_NORM: begin
                mac_rxd_d = mac_txd;
                mac_rxc_d = mac_txc;
                if (lb_req) begin
                    state_d = ST_LOOPBACK;
                end else if (both_idle) begin
                    mac_rxd_d = IDLE_W;
                    mac_rxc_d = '1;
                    state_d   = ST_NORMAL;
                end else if (timeout) begin
                    mac_rxd_d = ERR_W;
                    mac_rxc_d = '1;
                    forced_d  = 1'b1;
                    state_d   = ST_NORMAL;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = ST_NORMAL;
        endcase

        // PCS TX follows the next-state so it flips with the mac_rx source.
        lb_active_d = (state_d == ST_LOOPBACK) || (state_d == ST_TO_NORM);
        if ((TX_IDLE_IN_LB != 0) && lb_active_d) begin
            pcs_txd_d = IDLE_W;
            pcs_txc_d = '1;
        end else begin
            pcs_txd_d = mac_txd;
            pcs_txc_d = mac_txc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_NORMAL;
            cnt_q       <= '0;
            forced_q    <= 1'b0;
            lb_active_q <= 1'b0;
            mac_rxd_q   <= IDLE_W;
            mac_rxc_q   <= '1;
            pcs_txd_q   <= IDLE_W;
            pcs_txc_q   <= '1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            forced_q    <= forced_d;
            lb_active_q <= lb_active_d;
            mac_rxd_q   <= mac_rxd_d;
            mac_rxc_q   <= mac_rxc_d;
            pcs_txd_q   <= pcs_txd_d;
            pcs_txc_q   <= pcs_txc_d;
        end
    end

    assign mac_rxd   = mac_rxd_q;
    assign mac_rxc   = mac_rxc_q;
    assign pcs_txd   = pcs_txd_q;
    assign pcs_txc   = pcs_txc_q;
    assign lb_active = lb_active_q;
    assign forced_sw = forced_q;

endmodule

// File: rtl/xgmii_lb_switch.sv
// N-lane XGMII crossbar between MAC and PCS with per-lane runtime loopback;
// each lane switches independently at idle boundaries.
module xgmii_lb_switch
    import xgmii_pkg::*;
#(
    parameter int LANES         = 4,
    parameter int DATA_W        = 64,
    parameter int TMO_W         = 12,
    parameter int TMO_CYC       = 2048,
    parameter int TX_IDLE_IN_LB = 0,
    localparam int CTRL_W       = DATA_W / 8
) (
    input  logic                    clk_156,
    input  logic                    reset_156m25_n,
    input  logic [LANES*DATA_W-1:0] mac_txd,
    input  logic [LANES*CTRL_W-1:0] mac_txc,
    input  logic [LANES*DATA_W-1:0] pcs_rxd,
    input  logic [LANES*CTRL_W-1:0] pcs_rxc,
    input  logic [LANES-1:0]        lb_req,
    input  logic                    clr_forced,
    output logic [LANES*DATA_W-1:0] pcs_txd,
    output logic [LANES*CTRL_W-1:0] pcs_txc,
    output logic [LANES*DATA_W-1:0] mac_rxd,
    output logic [LANES*CTRL_W-1:0] mac_rxc,
    output logic [LANES-1:0]        lb_active,
    output logic [LANES-1:0]        forced_sw
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        xgmii_lb_lane #(
            .DATA_W       (DATA_W),
            .CTRL_W       (CTRL_W),
            .TMO_W        (TMO_W),
            .TMO_CYC      (TMO_CYC),
            .TX_IDLE_IN_LB(TX_IDLE_IN_LB)
        ) u_lane (
            .clk       (clk_156),
            .rst_n     (reset_156m25_n),
            .mac_txd   (mac_txd[i*DATA_W +: DATA_W]),
            .mac_txc   (mac_txc[i*CTRL_W +: CTRL_W]),
            .pcs_rxd   (pcs_rxd[i*DATA_W +: DATA_W]),
            .pcs_rxc   (pcs_rxc[i*CTRL_W +: CTRL_W]),
            .lb_req    (lb_req[i]),
            .clr_forced(clr_forced),
            .pcs_txd   (pcs_txd[i*DATA_W +: DATA_W]),
            .pcs_txc   (pcs_txc[i*CTRL_W +: CTRL_W]),
            .mac_rxd   (mac_rxd[i*DATA_W +: DATA_W]),
            .mac_rxc   (mac_rxc[i*CTRL_W +: CTRL_W]),
            .lb_active (lb_active[i]),
            .forced_sw (forced_sw[i])
        );
    end

endmodule

// File: tb/tb_xgmii_lb_switch.sv
// Directed bench for xgmii_lb_switch: reset, loopback entry/exit, frame-boundary
// wait, forced timeout, withdrawal and PCS TX idling.
module tb_xgmii_lb_switch;

    localparam int LANES = 4;
    localparam int DW    = 64;
    localparam int CW    = 8;
    localparam logic [63:0] IDLE_D = 64'h0707070707070707;
    localparam logic [63:0] ERR_D  = 64'hFEFEFEFEFEFEFEFE;
    localparam logic [63:0] P_D    = 64'h0123456789ABCDEF;
    localparam logic [63:0] E_D    = 64'hCAFE0000BEEF0001;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [LANES*DW-1:0]  mac_txd, pcs_rxd, pcs_txd, mac_rxd;
    logic [LANES*CW-1:0]  mac_txc, pcs_rxc, pcs_txc, mac_rxc;
    logic [LANES-1:0]     lb_req, lb_active, forced_sw;
    logic                 clr_forced;

    int checks = 0;
    int errors = 0;
    int bad;

    always #5 clk = ~clk;

    xgmii_lb_switch #(.LANES(LANES), .DATA_W(DW), .TMO_W(12), .TMO_CYC(2048),
                      .TX_IDLE_IN_LB(1)) dut (
        .clk_156       (clk),
        .reset_156m25_n(rst_n),
        .mac_txd       (mac_txd),
        .mac_txc       (mac_txc),
        .pcs_rxd       (pcs_rxd),
        .pcs_rxc       (pcs_rxc),
        .lb_req        (lb_req),
        .clr_forced    (clr_forced),
        .pcs_txd       (pcs_txd),
        .pcs_txc       (pcs_txc),
        .mac_rxd       (mac_rxd),
        .mac_rxc       (mac_rxc),
        .lb_active     (lb_active),
        .forced_sw     (forced_sw)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_tx(input int ln, input logic [63:0] d, input logic [7:0] c);
        mac_txd[ln*DW +: DW] = d;
        mac_txc[ln*CW +: CW] = c;
    endtask

    task automatic set_rx(input int ln, input logic [63:0] d, input logic [7:0] c);
        pcs_rxd[ln*DW +: DW] = d;
        pcs_rxc[ln*CW +: CW] = c;
    endtask

    function automatic logic [63:0] rxd(input int ln);
        return mac_rxd[ln*DW +: DW];
    endfunction

    function automatic logic [63:0] txd(input int ln);
        return pcs_txd[ln*DW +: DW];
    endfunction

    function automatic logic [63:0] act();
        return {60'd0, lb_active};
    endfunction

    function automatic logic [63:0] frc();
        return {60'd0, forced_sw};
    endfunction

    function automatic logic [63:0] frame_word(input int k);
        return (k == 0) ? 64'hD5555555555555FB : (64'h1111222200000000 | 64'(k));
    endfunction

    function automatic logic [7:0] frame_ctrl(input int k);
        return (k == 0) ? 8'h01 : 8'h00;
    endfunction

    task automatic all_idle();
        for (int i = 0; i < LANES; i++) begin
            set_tx(i, IDLE_D, 8'hFF);
            set_rx(i, IDLE_D, 8'hFF);
        end
    endtask

    initial begin
        // Reset with every input toggling.
        rst_n = 1'b0;
        repeat (4) begin
            for (int i = 0; i < LANES; i++) begin
                set_tx(i, {$urandom(), $urandom()}, 8'($urandom_range(0, 255)));
                set_rx(i, {$urandom(), $urandom()}, 8'($urandom_range(0, 255)));
            end
            lb_req     = 4'($urandom_range(0, 15));
            clr_forced = 1'($urandom_range(0, 1));
            tick();
        end
        chk("rst_mac_rxd", mac_rxd[255:192] & mac_rxd[191:128] & mac_rxd[127:64] & mac_rxd[63:0], IDLE_D);
        chk("rst_mac_rxd_l0", rxd(0), IDLE_D);
        chk("rst_mac_rxc", {32'd0, mac_rxc}, 64'hFFFFFFFF);
        chk("rst_pcs_txd_l3", txd(3), IDLE_D);
        chk("rst_lb_active", act(), 64'h0);
        chk("rst_forced_sw", frc(), 64'h0);

        all_idle();
        lb_req     = '0;
        clr_forced = 1'b0;
        rst_n      = 1'b1;
        tick();
        chk("idle_pass_l2", rxd(2), IDLE_D);

        // Normal pass-through.
        set_rx(0, 64'h1122334455667788, 8'h00);
        set_tx(0, 64'h99AABBCCDDEEFF00, 8'h00);
        tick();
        chk("norm_mac_rxd_l0", rxd(0), 64'h1122334455667788);
        chk("norm_pcs_txd_l0", txd(0), 64'h99AABBCCDDEEFF00);
        all_idle();
        tick();

        // Lane 0 into loopback while both sources are idle.
        lb_req[0] = 1'b1;
        tick();
        chk("l0_enter_act0", act(), 64'h0);
        tick();
        chk("l0_idle_word", rxd(0), IDLE_D);
        chk("l0_act", act(), 64'h1);
        chk("l0_pcs_tx_idle", txd(0), IDLE_D);
        set_tx(0, 64'hA0A1A2A3A4A5A6A7, 8'h00);
        set_rx(0, 64'hB0B1B2B3B4B5B6B7, 8'h00);
        tick();
        chk("l0_lb_data", rxd(0), 64'hA0A1A2A3A4A5A6A7);
        chk("l0_lb_ctrl", {56'd0, mac_rxc[7:0]}, 64'h0);
        chk("l0_lb_pcs_tx", txd(0), IDLE_D);
        chk("l0_lb_l1_untouched", rxd(1), IDLE_D);
        set_tx(0, 64'hA8A9AAABACADAEAF, 8'h00);
        tick();
        chk("l0_lb_data2", rxd(0), 64'hA8A9AAABACADAEAF);

        // Lane 0 back to normal.
        all_idle();
        lb_req[0] = 1'b0;
        tick();
        chk("l0_to_norm_act", act(), 64'h1);
        tick();
        chk("l0_norm_act", act(), 64'h0);
        set_tx(0, 64'hC0C1C2C3C4C5C6C7, 8'h00);
        set_rx(0, 64'hD0D1D2D3D4D5D6D7, 8'h00);
        tick();
        chk("l0_norm_pcs_tx", txd(0), 64'hC0C1C2C3C4C5C6C7);
        chk("l0_norm_mac_rx", rxd(0), 64'hD0D1D2D3D4D5D6D7);
        all_idle();
        tick();

        // Lane 1: request arrives mid-frame, switch waits for the boundary.
        bad = 0;
        for (int k = 0; k < 200; k++) begin
            set_rx(1, frame_word(k), frame_ctrl(k));
            if (k == 10) lb_req[1] = 1'b1;
            tick();
            if (rxd(1) !== frame_word(k) || lb_active[1] !== 1'b0) bad++;
        end
        chk("l1_frame_intact", 64'(bad), 64'h0);
        set_rx(1, IDLE_D, 8'hFF);
        tick();
        chk("l1_switch_idle", rxd(1), IDLE_D);
        chk("l1_act", act(), 64'h2);
        chk("l1_no_force", frc(), 64'h0);
        set_tx(1, 64'h5A5A5A5A00000001, 8'h00);
        tick();
        chk("l1_lb_data", rxd(1), 64'h5A5A5A5A00000001);
        set_tx(1, IDLE_D, 8'hFF);
        lb_req[1] = 1'b0;
        tick();
        tick();
        chk("l1_back_norm", act(), 64'h0);

        // Lane 2: continuous traffic forces a timeout switch.
        set_rx(2, P_D, 8'h00);
        lb_req[2] = 1'b1;
        tick();
        bad = 0;
        repeat (2047) begin
            tick();
            if (rxd(2) !== P_D) bad++;
        end
        chk("l2_pre_tmo_pass", 64'(bad), 64'h0);
        chk("l2_pre_tmo_forced", frc(), 64'h0);
        tick();
        chk("l2_err_data", rxd(2), ERR_D);
        chk("l2_err_ctrl", {56'd0, mac_rxc[23:16]}, 64'hFF);
        chk("l2_forced", frc(), 64'h4);
        chk("l2_act", act(), 64'h4);
        clr_forced = 1'b1;
        tick();
        clr_forced = 1'b0;
        chk("l2_clr", frc(), 64'h0);
        set_tx(2, E_D, 8'h00);
        tick();
        chk("l2_lb_data", rxd(2), E_D);
        chk("l2_lb_pcs_tx", txd(2), IDLE_D);

        // Lane 2 return path times out too; clear coincides with the set.
        lb_req[2] = 1'b0;
        tick();
        bad = 0;
        repeat (2047) begin
            tick();
            if (rxd(2) !== E_D || txd(2) !== IDLE_D) bad++;
        end
        chk("l2_ret_pre_tmo", 64'(bad), 64'h0);
        clr_forced = 1'b1;
        tick();
        clr_forced = 1'b0;
        chk("l2_ret_err", rxd(2), ERR_D);
        chk("l2_set_beats_clr", frc(), 64'h4);
        chk("l2_ret_act", act(), 64'h0);
        chk("l2_ret_pcs_tx", txd(2), E_D);
        tick();
        chk("l2_sticky", frc(), 64'h4);
        clr_forced = 1'b1;
        tick();
        clr_forced = 1'b0;
        chk("l2_clr2", frc(), 64'h0);
        all_idle();
        tick();

        // Lane 3: short request pulse during a frame is withdrawn.
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            set_rx(3, frame_word(k), frame_ctrl(k));
            lb_req[3] = (k >= 5 && k < 10);
            tick();
            if (rxd(3) !== frame_word(k) || lb_active[3] !== 1'b0) bad++;
        end
        chk("l3_withdraw_frame", 64'(bad), 64'h0);
        set_rx(3, IDLE_D, 8'hFF);
        tick();
        tick();
        chk("l3_withdraw_act", act(), 64'h0);

        // Lane 3: boundary lands on the timeout cycle, boundary wins.
        set_rx(3, P_D, 8'h00);
        lb_req[3] = 1'b1;
        tick();
        repeat (2047) tick();
        set_rx(3, IDLE_D, 8'hFF);
        tick();
        chk("l3_tie_idle", rxd(3), IDLE_D);
        chk("l3_tie_no_force", frc(), 64'h0);
        chk("l3_tie_act", act(), 64'h8);
        lb_req[3] = 1'b0;
        tick();
        tick();
        chk("l3_tie_back", act(), 64'h0);

        // Lanes 0 and 2 looped together; PCS TX idles only on looped lanes.
        set_tx(1, 64'hF1F1F1F1F1F1F1F1, 8'h00);
        set_tx(3, 64'hF3F3F3F3F3F3F3F3, 8'h00);
        lb_req = 4'b0101;
        tick();
        tick();
        chk("tx_act_05", act(), 64'h5);
        chk("tx_l0_idle", txd(0), IDLE_D);
        chk("tx_l1_pass", txd(1), 64'hF1F1F1F1F1F1F1F1);
        chk("tx_l2_idle", txd(2), IDLE_D);
        chk("tx_l3_pass", txd(3), 64'hF3F3F3F3F3F3F3F3);
        set_tx(0, 64'h0000000000000A0A, 8'h00);
        set_tx(2, 64'h0000000000000C0C, 8'h00);
        tick();
        chk("tx_l0_lb_rx", rxd(0), 64'h0000000000000A0A);
        chk("tx_l2_lb_rx", rxd(2), 64'h0000000000000C0C);
        chk("tx_l0_still_idle", txd(0), IDLE_D);
        chk("tx_l1_rx_norm", rxd(1), IDLE_D);
        set_tx(0, IDLE_D, 8'hFF);
        lb_req[0] = 1'b0;
        tick();
        tick();
        chk("tx_act_04", act(), 64'h4);
        set_tx(0, 64'h0000000000000B0B, 8'h00);
        tick();
        chk("tx_l0_restored", txd(0), 64'h0000000000000B0B);
        chk("tx_l2_still_idle", txd(2), IDLE_D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xgmii_lb_switch.md
Name: xgmii_lb_switch

Overview:
- Parametrised N-lane XGMII crossbar between xge_mac instances and PCS_core instances in the 40GbE datapath.
- Replaces the hardwired MAC-TX to MAC-RX loopback with a per-lane runtime-selectable loopback.
- Mode changes are made only at idle boundaries, so the MAC never sees a truncated frame.
- A timeout forces the switch and flags the event.

Parameters:
- LANES, 4, number of independent XGMII lanes (1..8)
- DATA_W, 64, XGMII data bits per lane; CTRL_W = DATA_W/8
- TMO_W, 12, width of the switch-timeout counter
- TMO_CYC, 2048, cycles to wait for an idle boundary before a forced switch (must be < 2^TMO_W)
- TX_IDLE_IN_LB, 0, 1 = PCS TX receives idle while its lane is in loopback; 0 = MAC TX is still mirrored to PCS TX

Ports:
- clk_156  in  1  156.25 MHz XGMII/core clock
- reset_156m25_n  in  1  reset, synchronous, active-low
- mac_txd  in  LANES*DATA_W  MAC XGMII TX data, lane i at [i*DATA_W +: DATA_W]
- mac_txc  in  LANES*CTRL_W  MAC XGMII TX control
- pcs_rxd  in  LANES*DATA_W  PCS_core decoded RX data
- pcs_rxc  in  LANES*CTRL_W  PCS_core RX control
- lb_req  in  LANES  per-lane loopback request, level (1 = loopback)
- clr_forced  in  1  single-cycle clear of all forced_sw bits
- pcs_txd  out  LANES*DATA_W  to PCS_core TX
- pcs_txc  out  LANES*CTRL_W
- mac_rxd  out  LANES*DATA_W  to MAC RX
- mac_rxc  out  LANES*CTRL_W
- lb_active  out  LANES  1 = lane currently in loopback
- forced_sw  out  LANES  sticky, lane switched by timeout

Behaviour:
- Definitions:
  - IDLE word: ctrl = all 1s, every data byte 0x07.
  - ERR word: ctrl = all 1s, every data byte 0xFE.
- Reset (sync, reset_156m25_n = 0 at a clk_156 edge):
  - All data outputs = IDLE data; all ctrl outputs = all 1s.
  - lb_active = 0; forced_sw = 0; timeout counters = 0; every lane FSM = NORMAL.
  - Reset taking effect mid-drain abandons the drain immediately.
- Latency: every output registered, exactly 1 cycle from input to output.
- Per-lane FSM, states NORMAL, TO_LB, LOOPBACK, TO_NORM:
  - NORMAL: mac_rx = pcs_rx. lb_req = 1 -> TO_LB, counter cleared.
  - TO_LB: mac_rx = pcs_rx, counter increments every cycle.
    - Exit when pcs_rx word is IDLE and mac_tx word is IDLE in the same cycle.
    - On exit: output IDLE on mac_rx that cycle, go to LOOPBACK, lb_active = 1 on the next output cycle.
  - Timeout in TO_LB: counter reaching TMO_CYC-1 without a boundary -> output one ERR word on mac_rx, set forced_sw[i], go to LOOPBACK.
  - Withdrawn request in TO_LB: lb_req drops -> return to NORMAL with no idle inserted; pass-through continues uninterrupted.
  - LOOPBACK: mac_rx = mac_tx. lb_req = 0 -> TO_NORM.
  - TO_NORM: mirror of TO_LB with sources swapped; the same idle condition, timeout and withdrawal rules apply. Exit -> NORMAL, lb_active = 0.
- Boundary ordering:
  - If the idle boundary and the timeout occur in the same cycle, the idle boundary wins: no ERR, no forced_sw.
  - If clr_forced and a forced event occur in the same cycle, the set wins.
- PCS TX path:
  - pcs_tx = mac_tx always, except when TX_IDLE_IN_LB = 1 and the lane is in LOOPBACK or TO_NORM; then pcs_tx = IDLE.
  - The PCS TX path switches to/from IDLE on the same cycle the lane's mac_rx source changes.
- Counter is TMO_W bits, saturates, and never wraps.
- Lanes are fully independent; there is no cross-lane alignment.

Decomposition:
- Package xgmii_pkg holds:
  - the IDLE and ERR byte constants (0x07, 0xFE) and XGMII_DW = 64;
  - the lane-state encoding (NORMAL = 0, TO_LB = 1, LOOPBACK = 2, TO_NORM = 3);
  - an is_idle word function.
- One sub-module, xgmii_lb_lane: a single lane's FSM, counter, muxes and output registers.
- The top level is a generate loop of LANES instances plus the forced_sw clear fan-out.

Test Plan:
- Reset with all inputs toggling -> the cycle after reset release: mac_rxd lane 0 = 0x0707070707070707, mac_rxc = 0xFF, lb_active = 0.
- lb_req[0] = 1 while both sources are IDLE -> IDLE on mac_rx lane 0 one cycle later; from the following cycle mac_rxd lane 0 equals mac_txd lane 0 delayed 1; lb_active = 0x1.
- lb_req[1] = 1 during a 200-cycle pcs_rx frame on lane 1 -> no switch until the frame ends; the switch occurs on the first cycle both sources are IDLE; no ERR; forced_sw = 0.
- Continuous non-idle traffic on lane 2, lb_req[2] = 1 -> exactly 2048 cycles later one ERR word (0xFEFEFEFEFEFEFEFE, ctrl 0xFF) on mac_rx lane 2; forced_sw = 0x4; clr_forced pulse -> 0x0.
- lb_req[3] pulsed for 5 cycles during a frame -> lane 3 stays NORMAL; pcs_rx frame passes unmodified; lb_active[3] = 0.
- Lanes 0 and 2 toggled independently with TX_IDLE_IN_LB = 1 -> pcs_tx lane 0 = IDLE only while lane 0 is looped; lanes 1 and 3 unaffected.
